// File: rtl/receiver_uart.sv
// UART 8N1 receiver: 2-FF input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready holding register with framing and overrun flags.
module receiver_uart #(
  parameter int clk_freq_hz = 16_000_000,
  parameter int baud_rate   = 57600
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int DIV = clk_freq_hz / baud_rate;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bitcnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      tdata_q;
  logic            tvalid_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic            tick;
  logic            counting;

  assign tick     = (cnt_q == '0);
  assign counting = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= i_uart_rx;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (tvalid_q && i_tready) tvalid_q <= 1'b0;
      if (counting && !tick) cnt_q <= cnt_q - CNT_ONE;

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= CNT_HALF;
          end
        end
        S_START: begin
          if (tick) begin
            if (!rx_s_q) begin
              state_q  <= S_DATA;
              cnt_q    <= CNT_FULL;
              bitcnt_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q  <= {rx_s_q, shift_q[7:1]};
            cnt_q    <= CNT_FULL;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_s_q) begin
              // Returning to IDLE at mid-stop lets a start edge in the second half be caught.
              state_q <= S_IDLE;
              if (!tvalid_q || i_tready) begin
                tdata_q  <= shift_q;
                tvalid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tdata     = tdata_q;
  assign o_tvalid    = tvalid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule
